// File: rtl/prefix_adder8.sv
// prefix_adder8: registered 8-bit Kogge-Stone adder with carry, overflow and zero flags.
module prefix_adder8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout,
  output logic       overflow,
  output logic       zero
);
  logic [3:0][8:0] gk;
  logic [3:0][8:0] pk;
  logic [7:0] c;
  logic [7:0] s;
  logic       co;
  assign gk[0] = {a & b, cin};
  assign pk[0] = {a ^ b, 1'b0};
  // Position 0 carries cin; position i+1 holds bit i, so gk[3][i] is the carry into bit i.
  for (genvar l = 0; l < 3; l++) begin : lv
    for (genvar j = 0; j < 9; j++) begin : bt
      if (j >= (1 << l)) begin : op
        assign gk[l+1][j] = gk[l][j] | (pk[l][j] & gk[l][j-(1<<l)]);
        assign pk[l+1][j] = pk[l][j] & pk[l][j-(1<<l)];
      end else begin : pass
        assign gk[l+1][j] = gk[l][j];
        assign pk[l+1][j] = pk[l][j];
      end
    end
  end
  assign c  = gk[3][7:0];
  assign s  = pk[0][8:1] ^ c;
  assign co = gk[0][8] | (pk[0][8] & c[7]);
  always_ff @(posedge clk) begin
    if (reset) begin
      y        <= 8'h00;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      y        <= s;
      cout     <= co;
      overflow <= c[7] ^ co;
      zero     <= ~|s;
    end
  end
endmodule

// File: tb/tb_prefix_adder8.sv
// tb_prefix_adder8: directed and random checks of prefix_adder8 against an arithmetic model.
module tb_prefix_adder8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic [7:0] y;
  logic       cout;
  logic       overflow;
  logic       zero;
  int n_cmp = 0;
  int n_err = 0;
  prefix_adder8 dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin),
    .y(y), .cout(cout), .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  // Packed as {cout, overflow, zero, y}.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc, input logic mr);
    int sa, sb, ss;
    logic [8:0] u;
    if (mr) return {1'b0, 1'b0, 1'b1, 8'h00};
    u  = {1'b0, ma} + {1'b0, mb} + {8'h00, mc};
    sa = ma[7] ? int'(ma) - 256 : int'(ma);
    sb = mb[7] ? int'(mb) - 256 : int'(mb);
    ss = sa + sb + int'(mc);
    return {u[8], (ss > 127 || ss < -128), u[7:0] == 8'h00, u[7:0]};
  endfunction
  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got cout/ovf/zero/y=%b/%b/%b/%h want %b/%b/%b/%h",
               tag, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic tr);
    a = ta;
    b = tb;
    cin = tc;
    reset = tr;
    @(posedge clk);
    #1;
    check(tag, {cout, overflow, zero, y}, model(ta, tb, tc, tr));
  endtask
  initial begin
    logic [10:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {cout, overflow, zero, y}, {1'b0, 1'b0, 1'b1, 8'h00});
    check("reset_lit", {cout, overflow, zero, y}, 11'b001_0000_0000);
    step("basic", 8'h12, 8'h34, 1'b0, 1'b0);
    check("basic_lit", {cout, overflow, zero, y}, {1'b0, 1'b0, 1'b0, 8'h46});
    step("ovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0);
    check("ovf_pos_lit", {cout, overflow, zero, y}, {1'b0, 1'b1, 1'b0, 8'h80});
    step("ovf_neg", 8'h80, 8'h80, 1'b0, 1'b0);
    check("ovf_neg_lit", {cout, overflow, zero, y}, {1'b1, 1'b1, 1'b1, 8'h00});
    step("ripple", 8'hFF, 8'h00, 1'b1, 1'b0);
    check("ripple_lit", {cout, overflow, zero, y}, {1'b1, 1'b0, 1'b1, 8'h00});
    step("b2b0", 8'h01, 8'h01, 1'b0, 1'b0);
    check("b2b0_lit", {cout, overflow, zero, y}, {1'b0, 1'b0, 1'b0, 8'h02});
    step("b2b1", 8'hF0, 8'h0F, 1'b1, 1'b0);
    check("b2b1_lit", {cout, overflow, zero, y}, {1'b1, 1'b0, 1'b1, 8'h00});
    step("b2b2", 8'h55, 8'hAA, 1'b0, 1'b0);
    check("b2b2_lit", {cout, overflow, zero, y}, {1'b0, 1'b0, 1'b0, 8'hFF});
    held = {cout, overflow, zero, y};
    a = 8'h80;
    b = 8'h80;
    cin = 1'b1;
    #3;
    check("hold", {cout, overflow, zero, y}, held);
    reset = 1'b1;
    #1;
    check("no_async_reset", {cout, overflow, zero, y}, held);
    @(posedge clk);
    #1;
    check("mid_reset", {cout, overflow, zero, y}, {1'b0, 1'b0, 1'b1, 8'h00});
    step("after_reset", 8'h80, 8'h7F, 1'b1, 1'b0);
    check("after_reset_lit", {cout, overflow, zero, y}, {1'b1, 1'b0, 1'b1, 8'h00});
    for (int i = 0; i < 10000; i++)
      step((i == 5000 || i == 5001) ? "rand_reset" : "rand",
           8'($urandom), 8'($urandom), 1'($urandom), i == 5000 || i == 5001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prefix_adder8.md
PREFIX_ADDER8 -- requirements
Module: prefix_adder8

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 a  input  8  addend A, unsigned or two's complement.
REQ-005 b  input  8  addend B, unsigned or two's complement.
REQ-006 cin  input  1  carry-in to bit 0.
REQ-007 y  output  8  registered sum bits [7:0].
REQ-008 cout  output  1  registered carry-out of bit 7.
REQ-009 overflow  output  1  registered signed (two's complement) overflow flag.
REQ-010 zero  output  1  registered flag, 1 when y == 8'h00.

Function
REQ-011 Sum SHALL be computed as {cout, y} = a + b + cin, full 9-bit result, no truncation other than the split into cout and y.
REQ-012 Carry network SHALL be a parallel-prefix (Kogge-Stone) structure: bitwise generate g_i = a_i & b_i, propagate p_i = a_i ^ b_i; cin folded in as group (g,p) at position -1; log2(8) = 3 prefix levels (spans 1, 2, 4) using the operator (G,P)o(G',P') = (G | P&G', P&P').
REQ-013 Sum bits SHALL be y_i = p_i ^ c_i, with c_0 = cin and c_i the group carry out of bits [i-1:0].
REQ-014 overflow SHALL equal c_7 XOR cout (carry into bit 7 XOR carry out of bit 7).
REQ-015 zero SHALL be 1 exactly when all 8 sum bits are 0, independent of cout and overflow.
REQ-016 Latency SHALL be exactly 1 clock: inputs sampled at rising edge N appear on all outputs after edge N, simultaneously.
REQ-017 Block SHALL accept new operands every cycle (throughput 1/cycle); no handshake, no stall, no valid signal.
REQ-018 All four outputs SHALL be driven only from registers; no combinational path from inputs to outputs.
REQ-019 Outputs SHALL hold their value between edges; inputs may change freely mid-cycle without effect until the next edge.
REQ-020 Wrap-around: sums above 8'hFF SHALL wrap modulo 256 with cout = 1; no saturation.
REQ-021 X/undriven inputs are illegal; behaviour with X inputs is not specified.

Reset
REQ-022 When reset is high at a rising edge, registers SHALL load y = 8'h00, cout = 0, overflow = 0, zero = 1, overriding the computed result.
REQ-023 Reset asserted mid-stream SHALL discard the operand sampled in that cycle; the first result after reset deassertion corresponds to operands sampled at the first edge with reset low.
REQ-024 No output SHALL change asynchronously on reset assertion; changes occur only at the clk edge.

Verification
REQ-025 Reset: hold reset high for 2 edges -> y=8'h00, cout=0, overflow=0, zero=1.
REQ-026 a=8'h12, b=8'h34, cin=0 -> next edge y=8'h46, cout=0, overflow=0, zero=0.
REQ-027 a=8'h7F, b=8'h01, cin=0 -> y=8'h80, cout=0, overflow=1, zero=0; a=8'h80, b=8'h80, cin=0 -> y=8'h00, cout=1, overflow=1, zero=1.
REQ-028 a=8'hFF, b=8'h00, cin=1 -> y=8'h00, cout=1, overflow=0, zero=1 (full carry ripple through all prefix levels).
REQ-029 Back-to-back: drive (8'h01,8'h01,0), (8'hF0,8'h0F,1), (8'h55,8'hAA,0) on consecutive edges -> outputs y=8'h02, then 8'h00 (cout=1, zero=1), then 8'hFF (cout=0, zero=0), one cycle behind each input.
REQ-030 Random: 10,000 random a/b/cin vectors compared one cycle later against a behavioural 9-bit sum and overflow model, with reset pulsed mid-run -> zero mismatches; reset cycle yields the REQ-022 values.
